// File: rtl/carry_ctrl_pipe_pkg.sv
// ============================================================================
// Module      : carry_ctrl_pipe_pkg
// Description : Shared codes, limits and per-lane carry select helper for
//               the post-adder carry-in select / pipeline block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package carry_ctrl_pipe_pkg;

    localparam int c_max_carryinreg = 2;
    localparam int c_max_lanes      = 4;

    localparam logic [1:0] c_cisel_zero = 2'b00;
    localparam logic [1:0] c_cisel_one  = 2'b01;
    localparam logic [1:0] c_cisel_op5  = 2'b10;
    localparam logic [1:0] c_cisel_cin  = 2'b11;

    typedef enum logic [2:0] {
        SEL_OPMODE5 = 3'd0,
        SEL_CARRYIN = 3'd1,
        SEL_ZERO    = 3'd2,
        SEL_ONE     = 3'd3,
        SEL_DYNAMIC = 3'd4,
        SEL_INVALID = 3'd7
    } sel_mode_e;

    function automatic logic sel_lane(
        input sel_mode_e  mode,
        input logic [1:0] cisel,
        input logic       op5,
        input logic       cin
    );
        logic w_bit;
        w_bit = 1'b0;
        case (mode)
            SEL_OPMODE5: w_bit = op5;
            SEL_CARRYIN: w_bit = cin;
            SEL_ZERO:    w_bit = 1'b0;
            SEL_ONE:     w_bit = 1'b1;
            SEL_DYNAMIC: begin
                case (cisel)
                    c_cisel_zero: w_bit = 1'b0;
                    c_cisel_one:  w_bit = 1'b1;
                    c_cisel_op5:  w_bit = op5;
                    c_cisel_cin:  w_bit = cin;
                    default:      w_bit = 1'b0;
                endcase
            end
            default:     w_bit = 1'b0;
        endcase
        return w_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/carry_pipe_stage.sv
// ============================================================================
// Module      : carry_pipe_stage
// Description : One clock-enabled, synchronously reset register holding the
//               lane carries plus their valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_pipe_stage #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/carry_ctrl_pipe.sv
// ============================================================================
// Module      : carry_ctrl_pipe
// Description : Per-lane carry-in source select with 0..2 enabled pipeline
//               stages, valid tracking and an optional carry-out register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_ctrl_pipe
    import carry_ctrl_pipe_pkg::*;
#(
    parameter string CARRYINSEL  = "OPMODE5",
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    LANES       = 1
) (
    input  logic             clk,
    input  logic             rstcarryin,
    input  logic             cecarryin,
    input  logic             cecarryout,
    input  logic [1:0]       cisel,
    input  logic [LANES-1:0] opmode5,
    input  logic [LANES-1:0] carryin,
    input  logic             vld_in,
    input  logic [LANES-1:0] carry_post,
    output logic [LANES-1:0] carryin_q,
    output logic             vld_out,
    output logic [LANES-1:0] carryout,
    output logic [LANES-1:0] carryoutf
);

    localparam sel_mode_e c_sel_mode =
        (CARRYINSEL == "OPMODE5") ? SEL_OPMODE5 :
        (CARRYINSEL == "CARRYIN") ? SEL_CARRYIN :
        (CARRYINSEL == "ZERO")    ? SEL_ZERO    :
        (CARRYINSEL == "ONE")     ? SEL_ONE     :
        (CARRYINSEL == "DYNAMIC") ? SEL_DYNAMIC : SEL_INVALID;

    // Illegal configurations stop elaboration rather than producing a quiet 0.
    generate
        if (c_sel_mode == SEL_INVALID) begin : g_bad_carryinsel
            $error("carry_ctrl_pipe: unsupported CARRYINSEL value");
        end
        if (CARRYINREG < 0 || CARRYINREG > c_max_carryinreg) begin : g_bad_carryinreg
            $error("carry_ctrl_pipe: CARRYINREG must be 0..2");
        end
        if (LANES < 1 || LANES > c_max_lanes) begin : g_bad_lanes
            $error("carry_ctrl_pipe: LANES must be 1..4");
        end
        if (CARRYOUTREG != 0 && CARRYOUTREG != 1) begin : g_bad_carryoutreg
            $error("carry_ctrl_pipe: CARRYOUTREG must be 0 or 1");
        end
    endgenerate

    logic [LANES-1:0] w_sel;
    logic [LANES:0]   w_chain [0:CARRYINREG];
    logic [LANES-1:0] w_carryout;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_sel[l] = sel_lane(c_sel_mode, cisel, opmode5[l], carryin[l]);
        end
    endgenerate

    // cisel affects only the selected bit, so it travels with the data for free.
    assign w_chain[0] = {vld_in, w_sel};

    generate
        for (genvar s = 0; s < CARRYINREG; s++) begin : g_stage
            carry_pipe_stage #(
                .WIDTH (LANES + 1)
            ) u_stage (
                .clk  (clk),
                .rst  (rstcarryin),
                .i_ce (cecarryin),
                .i_d  (w_chain[s]),
                .o_q  (w_chain[s+1])
            );
        end
    endgenerate

    assign carryin_q = w_chain[CARRYINREG][LANES-1:0];
    assign vld_out   = w_chain[CARRYINREG][LANES];

    generate
        if (CARRYOUTREG == 1) begin : g_co_reg
            logic [LANES-1:0] r_carryout;
            always_ff @(posedge clk) begin
                if (rstcarryin) begin
                    r_carryout <= '0;
                end else if (cecarryout) begin
                    r_carryout <= carry_post;
                end
            end
            assign w_carryout = r_carryout;
        end else begin : g_co_comb
            assign w_carryout = carry_post;
        end
    endgenerate

    assign carryout  = w_carryout;
    assign carryoutf = w_carryout;

endmodule

`default_nettype wire

// File: tb/tb_carry_ctrl_pipe.sv
// ============================================================================
// Module      : tb_carry_ctrl_pipe
// Description : Scoreboard bench for carry_ctrl_pipe (dynamic 4-lane, 2-stage
//               instance plus a combinational ONE / pass-through instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_carry_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic       ceo = 1'b0;
    logic [1:0] cisel = 2'b00;
    logic [3:0] op5 = 4'h0;
    logic [3:0] cin = 4'h0;
    logic       vld = 1'b0;
    logic [3:0] cpost = 4'h0;

    logic [3:0] q2, co2, cof2;
    logic       v2;
    logic [3:0] q0, co0, cof0;
    logic       v0;

    always #5 clk = ~clk;

    carry_ctrl_pipe #(
        .CARRYINSEL ("DYNAMIC"), .CARRYINREG (2), .CARRYOUTREG (1), .LANES (4)
    ) dut (
        .clk (clk), .rstcarryin (rst), .cecarryin (ce), .cecarryout (ceo),
        .cisel (cisel), .opmode5 (op5), .carryin (cin), .vld_in (vld),
        .carry_post (cpost), .carryin_q (q2), .vld_out (v2),
        .carryout (co2), .carryoutf (cof2)
    );

    carry_ctrl_pipe #(
        .CARRYINSEL ("ONE"), .CARRYINREG (0), .CARRYOUTREG (0), .LANES (4)
    ) dut0 (
        .clk (clk), .rstcarryin (rst), .cecarryin (ce), .cecarryout (ceo),
        .cisel (cisel), .opmode5 (op5), .carryin (cin), .vld_in (vld),
        .carry_post (cpost), .carryin_q (q0), .vld_out (v0),
        .carryout (co0), .carryoutf (cof0)
    );

    typedef struct {
        logic [3:0] d;
        int         age;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each lane picks a source from the 2-bit code, no lane interaction.
    function automatic logic [3:0] ref_sel(input logic [1:0] s, input logic [3:0] o, input logic [3:0] c);
        case (s)
            2'b00:   return 4'h0;
            2'b01:   return 4'hF;
            2'b10:   return o;
            default: return c;
        endcase
    endfunction

    // Monitor state
    logic       mon_on   = 1'b0;
    logic       en_last  = 1'b0;
    logic       rst_last = 1'b0;
    logic [3:0] m_co     = 4'h0;
    logic [3:0] prev_q   = 4'h0;
    logic       prev_v   = 1'b0;

    always @(posedge clk) begin
        en_last  = ce && !rst;
        rst_last = rst;
        if (rst) begin
            mon_on = 1'b1;
            exp_q.delete();
            m_co = 4'h0;
        end else begin
            if (ce) begin
                foreach (exp_q[k]) exp_q[k].age++;
            end
            if (ceo) m_co = cpost;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_last) begin
                check("reset_vld_out", {31'b0, v2}, 32'd0);
                check("reset_carryin_q", {28'b0, q2}, 32'd0);
            end else if (en_last) begin
                if (exp_q.size() > 0 && exp_q[0].age >= 2) begin
                    check("vld_out_at_latency", {31'b0, v2}, 32'd1);
                    check("carryin_q_data", {28'b0, q2}, {28'b0, exp_q[0].d});
                    void'(exp_q.pop_front());
                end else begin
                    check("vld_out_idle", {31'b0, v2}, 32'd0);
                end
            end else begin
                check("stall_hold_vld", {31'b0, v2}, {31'b0, prev_v});
                check("stall_hold_data", {28'b0, q2}, {28'b0, prev_q});
            end
            check("carryout_reg", {28'b0, co2}, {28'b0, m_co});
            check("carryoutf_eq", {28'b0, cof2}, {28'b0, co2});
            check("comb_one_q", {28'b0, q0}, 32'hF);
            check("comb_vld_pass", {31'b0, v0}, {31'b0, vld});
            check("comb_carryout", {28'b0, co0}, {28'b0, cpost});
            check("comb_carryoutf", {28'b0, cof0}, {28'b0, cpost});
            prev_q = q2;
            prev_v = v2;
        end
    end

    task automatic drive(input logic r, input logic e, input logic eo, input logic [1:0] s,
                         input logic [3:0] o, input logic [3:0] c, input logic v, input logic [3:0] p);
        @(posedge clk);
        #2;
        rst = r; ce = e; ceo = eo; cisel = s; op5 = o; cin = c; vld = v; cpost = p;
        if (e && v && !r) exp_q.push_back('{d: ref_sel(s, o, c), age: 0});
    endtask

    initial begin
        repeat (2) drive(1'b1, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0);

        // Dynamic select sweep: expect 0,F,A,5 two enabled cycles later.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, i[1:0], 4'hA, 4'h5, 1'b1, 4'h9);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 2'b00, 4'hA, 4'h5, 1'b0, 4'h3);

        // Valid pulse followed by a three-cycle stall.
        drive(1'b0, 1'b1, 1'b1, 2'b10, 4'hC, 4'h0, 1'b1, 4'h6);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 2'b11, 4'h0, 4'hF, 1'b1, 4'h3);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'h3);

        // Pipe full of ones, then reset with CE high.
        repeat (2) drive(1'b0, 1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b1, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b1, 4'hF);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'h3);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
        end

        drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
